serial_sub_seq: RTL and testbench

- Bit-serial subtractor: computes diff = a - b - b_in one bit per clock, LSB first.
- Uses a single full-subtractor cell and a borrow flip-flop.
- Counterpart to the team's ripple-carry adders: the parallel add becomes a serial subtract.
- Sits in the lab datapath as an ALU helper; controlled with a start/ready/done handshake.

---
 rtl/sub_pkg.sv | 13 +
 rtl/fs_bit.sv | 14 +
 rtl/serial_sub_seq.sv | 122 ++++++++++++
 tb/tb_serial_sub_seq.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sub_pkg.sv
// Shared types for the bit-serial subtractor.
// Holds the FSM state encoding and the default operand width.
package sub_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int W_DEF = 4;

endpackage

// File: rtl/fs_bit.sv
// Combinational 1-bit full subtractor: d = x - y - bi, bo = borrow out.
// Ports: x, y, bi in; d, bo out.
module fs_bit (
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic d,
  output logic bo
);

  assign d  = x ^ y ^ bi;
  assign bo = (~x & y) | (~(x ^ y) & bi);

endmodule

// File: rtl/serial_sub_seq.sv
// Bit-serial subtractor: diff = a - b - b_in, one bit per clock, LSB first.
// Ports: clk, rst, start/a/b/b_in in; ready, busy, done, diff, b_out, ovf out.
module serial_sub_seq
  import sub_pkg::*;
#(
  parameter  int W  = W_DEF,
  localparam int CW = $clog2(W) + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         b_in,
  output logic         ready,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] diff,
  output logic         b_out,
  output logic         ovf
);

  state_t         r_state;
  logic [W-1:0]   r_sa;
  logic [W-1:0]   r_sb;
  logic [W-1:0]   r_res;
  logic           r_borrow;
  logic [CW-1:0]  r_cnt;
  logic           r_amsb;
  logic           r_bmsb;
  logic           r_ready;
  logic           r_busy;
  logic           r_done;
  logic [W-1:0]   r_diff;
  logic           r_bout;
  logic           r_ovf;

  logic           w_d;
  logic           w_bo;
  logic [W-1:0]   w_res_nxt;

  fs_bit u_fs (
    .x  (r_sa[0]),
    .y  (r_sb[0]),
    .bi (r_borrow),
    .d  (w_d),
    .bo (w_bo)
  );

  assign w_res_nxt = {w_d, r_res[W-1:1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_sa     <= '0;
      r_sb     <= '0;
      r_res    <= '0;
      r_borrow <= 1'b0;
      r_cnt    <= '0;
      r_amsb   <= 1'b0;
      r_bmsb   <= 1'b0;
      r_ready  <= 1'b1;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_diff   <= '0;
      r_bout   <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_sa     <= a;
            r_sb     <= b;
            r_borrow <= b_in;
            r_cnt    <= '0;
            r_amsb   <= a[W-1];
            r_bmsb   <= b[W-1];
            r_ready  <= 1'b0;
            r_busy   <= 1'b1;
            r_state  <= SHIFT;
          end
        end
        SHIFT: begin
          r_sa     <= r_sa >> 1;
          r_sb     <= r_sb >> 1;
          r_borrow <= w_bo;
          r_res    <= w_res_nxt;
          r_cnt    <= r_cnt + CW'(1);
          // Last bit: publish results from the staged register
          // so outputs stay frozen while shifting.
          if (r_cnt == CW'(W - 1)) begin
            r_diff  <= w_res_nxt;
            r_bout  <= w_bo;
            r_ovf   <= (r_amsb != r_bmsb) && (w_d != r_amsb);
            r_done  <= 1'b1;
            r_state <= DONE;
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_ready <= 1'b1;
          r_state <= IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_ready <= 1'b1;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign ready = r_ready;
  assign busy  = r_busy;
  assign done  = r_done;
  assign diff  = r_diff;
  assign b_out = r_bout;
  assign ovf   = r_ovf;

endmodule

// File: tb/tb_serial_sub_seq.sv
// Self-checking bench for serial_sub_seq.
// Scoreboard of expected results, popped on every done pulse.
module tb_serial_sub_seq;

  localparam int W = 4;

  typedef struct {
    logic [W-1:0] d;
    logic         bo;
    logic         ov;
  } res_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         b_in;
  logic         ready;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         b_out;
  logic         ovf;

  res_t         sb_q[$];
  int           n_tests = 0;
  int           n_fail  = 0;
  int           n_done  = 0;
  logic [W-1:0] last_diff = '0;

  serial_sub_seq #(.W(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .b_in  (b_in),
    .ready (ready),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .b_out (b_out),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic res_t model(input logic [W-1:0] ma,
                                 input logic [W-1:0] mb,
                                 input logic mbi);
    res_t       r;
    logic [W:0] full;
    full = {1'b0, ma} - {1'b0, mb} - {{W{1'b0}}, mbi};
    r.d  = full[W-1:0];
    r.bo = full[W];
    r.ov = (ma[W-1] != mb[W-1]) && (r.d[W-1] != ma[W-1]);
    return r;
  endfunction

  always @(posedge clk) begin
    res_t e;
    #1;
    if (done === 1'b1) begin
      n_done++;
      chk("ready_with_done", {31'd0, ready}, 32'd0);
      if (sb_q.size() == 0) begin
        chk("spurious_done", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        chk("diff", {28'd0, diff}, {28'd0, e.d});
        chk("b_out", {31'd0, b_out}, {31'd0, e.bo});
        chk("ovf", {31'd0, ovf}, {31'd0, e.ov});
      end
    end
  end

  task automatic wait_ready();
    for (int i = 0; i < W + 4 && ready !== 1'b1; i++) begin
      @(posedge clk);
      #1;
    end
    chk("wait_ready", {31'd0, ready}, 32'd1);
  endtask

  task automatic do_op(input logic [W-1:0] ta,
                       input logic [W-1:0] tb,
                       input logic tbi);
    res_t e;
    int   lat;
    int   nd0;
    e = model(ta, tb, tbi);
    wait_ready();
    a     = ta;
    b     = tb;
    b_in  = tbi;
    start = 1'b1;
    sb_q.push_back(e);
    nd0 = n_done;
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = ~ta;
    b     = ~tb;
    b_in  = ~tbi;
    chk("busy_in_shift", {31'd0, busy}, 32'd1);
    chk("ready_in_shift", {31'd0, ready}, 32'd0);
    chk("diff_held", {28'd0, diff}, {28'd0, last_diff});
    lat = -1;
    for (int i = 1; i <= W + 3 && lat < 0; i++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) lat = i;
    end
    chk("latency", lat, W);
    @(posedge clk);
    #1;
    chk("ready_back", {31'd0, ready}, 32'd1);
    chk("done_count", n_done - nd0, 32'd1);
    last_diff = e.d;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    res_t e1;
    res_t e2;
    int   nd0;
    rst   = 1'b1;
    start = 1'b1;
    a     = '1;
    b     = '1;
    b_in  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst   = 1'b0;
    start = 1'b0;
    chk("rst_ready", {31'd0, ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_diff", {28'd0, diff}, 32'd0);
    chk("rst_b_out", {31'd0, b_out}, 32'd0);
    chk("rst_ovf", {31'd0, ovf}, 32'd0);

    do_op(4'd7, 4'd3, 1'b0);
    do_op(4'd3, 4'd7, 1'b0);
    do_op(4'd0, 4'd0, 1'b1);
    do_op(4'h8, 4'd1, 1'b0);
    do_op(4'h7, 4'hF, 1'b1);

    // Back-to-back: second start held high while busy.
    wait_ready();
    e1 = model(4'd5, 4'd2, 1'b0);
    e2 = model(4'd9, 4'd9, 1'b0);
    a     = 4'd5;
    b     = 4'd2;
    b_in  = 1'b0;
    start = 1'b1;
    sb_q.push_back(e1);
    nd0 = n_done;
    @(posedge clk);
    #1;
    a = 4'd9;
    b = 4'd9;
    for (int i = 1; i <= W; i++) begin
      @(posedge clk);
      #1;
      if (i < W) chk("b2b_busy", {31'd0, busy}, 32'd1);
    end
    chk("b2b_done1", {31'd0, done}, 32'd1);
    @(posedge clk);
    #1;
    chk("b2b_ready", {31'd0, ready}, 32'd1);
    chk("b2b_no_done", {31'd0, done}, 32'd0);
    sb_q.push_back(e2);
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("b2b_accept", {31'd0, busy}, 32'd1);
    for (int i = 1; i <= W; i++) begin
      @(posedge clk);
      #1;
    end
    chk("b2b_done2", {31'd0, done}, 32'd1);
    @(posedge clk);
    #1;
    chk("b2b_done_count", n_done - nd0, 32'd2);
    last_diff = e2.d;

    do_op(4'd3, 4'd7, 1'b0);

    // Abort mid-operation with reset.
    wait_ready();
    a     = 4'd6;
    b     = 4'd1;
    b_in  = 1'b0;
    start = 1'b1;
    nd0   = n_done;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("abort_diff", {28'd0, diff}, 32'd0);
    chk("abort_b_out", {31'd0, b_out}, 32'd0);
    chk("abort_ovf", {31'd0, ovf}, 32'd0);
    chk("abort_ready", {31'd0, ready}, 32'd1);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    repeat (W + 2) begin
      @(posedge clk);
      #1;
    end
    chk("abort_no_done", n_done - nd0, 32'd0);
    last_diff = '0;

    do_op(4'd2, 4'd3, 1'b0);

    chk("queue_empty", sb_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
